// File: rtl/dds_pkg.sv
// Shared definitions for the DDS voice engine.
//   - waveform select encodings
//   - per-voice configuration record
//   - output width derivation
package dds_pkg;

    localparam logic [1:0] WAVE_SQUARE   = 2'd0;
    localparam logic [1:0] WAVE_SAW      = 2'd1;
    localparam logic [1:0] WAVE_TRIANGLE = 2'd2;
    localparam logic [1:0] WAVE_PULSE25  = 2'd3;

    // Widest increment / amplitude the config record can carry; narrower
    // engine parameters are zero-extended into these fields.
    localparam int unsigned CFG_INC_MAX_W = 32;
    localparam int unsigned CFG_AMP_MAX_W = 8;

    typedef struct packed {
        logic                     en;
        logic [CFG_INC_MAX_W-1:0] inc;
        logic [1:0]               wave;
        logic [CFG_AMP_MAX_W-1:0] amp;
    } voice_cfg_t;

    // Mix width: one full-scale voice is wave_w + amp_w bits, and summing
    // num_voices of them needs clog2(num_voices) extra bits.
    function automatic int unsigned out_width(input int unsigned wave_w,
                                              input int unsigned amp_w,
                                              input int unsigned num_voices);
        return wave_w + amp_w + $clog2(num_voices);
    endfunction

endpackage

// File: rtl/dds_wave_lut.sv
// Combinational waveform shaper: turns the top bits of a phase accumulator
// into one voice's scaled contribution.
//   p_i       : phase bits (accumulator MSBs)
//   wave_i    : waveform select (square, saw, triangle, pulse-25%)
//   amp_i     : linear amplitude, 0 = silent
//   en_i      : voice enable; disabled voices contribute 0
//   contrib_o : shape * amp
module dds_wave_lut
    import dds_pkg::*;
#(
    parameter int unsigned WAVE_W = 8,
    parameter int unsigned AMP_W  = 4
) (
    input  logic [WAVE_W-1:0]       p_i,
    input  logic [1:0]              wave_i,
    input  logic [AMP_W-1:0]        amp_i,
    input  logic                    en_i,
    output logic [WAVE_W+AMP_W-1:0] contrib_o
);

    localparam int unsigned CW = WAVE_W + AMP_W;

    logic [WAVE_W-1:0] shape;
    logic [WAVE_W-1:0] tri_ramp;

    always_comb begin
        shape    = '0;
        // Triangle rises on the first half-cycle, mirrored on the second.
        tri_ramp = {p_i[WAVE_W-2:0], 1'b0};
        unique case (wave_i)
            WAVE_SQUARE:   shape = {WAVE_W{p_i[WAVE_W-1]}};
            WAVE_SAW:      shape = p_i;
            WAVE_TRIANGLE: shape = p_i[WAVE_W-1] ? ~tri_ramp : tri_ramp;
            WAVE_PULSE25:  shape = {WAVE_W{&p_i[WAVE_W-1 -: 2]}};
        endcase
        contrib_o = en_i ? CW'(shape) * CW'(amp_i) : '0;
    end

endmodule

// File: rtl/dds_voice_engine.sv
// Time-multiplexed DDS tone generator. NUM_VOICES phase accumulators share
// one RAM and are visited two cycles per voice (RD then WR); each voice's
// shaped sample is summed into a mix word emitted once per frame.
//   i_clk, i_res        : clock, synchronous active-high reset
//   i_cfg_*             : per-voice config write port (one voice per cycle)
//   o_sample            : mixed unsigned sample, held between frames
//   o_sample_valid      : one-cycle pulse when o_sample updates
//   o_init_busy         : high while the post-reset accumulator clear runs
module dds_voice_engine
    import dds_pkg::*;
#(
    parameter  int unsigned NUM_VOICES = 64,
    parameter  int unsigned ACC_W      = 26,
    parameter  int unsigned INC_W      = 24,
    parameter  int unsigned WAVE_W     = 8,
    parameter  int unsigned AMP_W      = 4,
    localparam int unsigned VA_W       = $clog2(NUM_VOICES),
    localparam int unsigned OUT_W      = out_width(WAVE_W, AMP_W, NUM_VOICES)
) (
    input  logic              i_clk,
    input  logic              i_res,
    input  logic              i_cfg_wren,
    input  logic [VA_W-1:0]   i_cfg_addr,
    input  logic              i_cfg_en,
    input  logic [INC_W-1:0]  i_cfg_inc,
    input  logic [1:0]        i_cfg_wave,
    input  logic [AMP_W-1:0]  i_cfg_amp,
    input  logic              i_cfg_phase_rst,
    output logic [OUT_W-1:0]  o_sample,
    output logic              o_sample_valid,
    output logic              o_init_busy
);

    localparam int unsigned CW = WAVE_W + AMP_W;

    typedef enum logic {StInit, StRun} state_t;

    state_t state_q, state_d;
    logic             ph_q;
    logic [VA_W-1:0]  idx_q;
    logic             last_voice;

    voice_cfg_t       cfg_q [NUM_VOICES];
    voice_cfg_t       cfg_wr;
    voice_cfg_t       cfg_rd_q;
    logic [NUM_VOICES-1:0] pend_q;

    logic [ACC_W-1:0] acc_mem [NUM_VOICES];
    logic [ACC_W-1:0] acc_rd_q;
    logic [ACC_W-1:0] acc_next;
    logic [INC_W-1:0] inc_rd;

    logic [CW-1:0]    contrib;
    logic [OUT_W-1:0] mix_q;
    logic [OUT_W-1:0] sample_q;
    logic             valid_q;

    // NUM_VOICES is a power of two, so all-ones is the last voice.
    assign last_voice = &idx_q;

    // ---------------- scanner / FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:  if (ph_q && last_voice) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state_q <= StInit;
            ph_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ~ph_q;
            if (ph_q) idx_q <= idx_q + 1'b1;
        end
    end

    // ---------------- config store ----------------
    always_comb begin
        cfg_wr      = '0;
        cfg_wr.en   = i_cfg_en;
        cfg_wr.inc  = CFG_INC_MAX_W'(i_cfg_inc);
        cfg_wr.wave = i_cfg_wave;
        cfg_wr.amp  = CFG_AMP_MAX_W'(i_cfg_amp);
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            for (int v = 0; v < NUM_VOICES; v++) cfg_q[v] <= '0;
            pend_q   <= '0;
            cfg_rd_q <= '0;
        end else begin
            // Scanner clear first so a same-cycle host set wins.
            if (ph_q) pend_q[idx_q] <= 1'b0;
            if (i_cfg_wren) begin
                cfg_q[i_cfg_addr] <= cfg_wr;
                if (i_cfg_phase_rst) pend_q[i_cfg_addr] <= 1'b1;
            end
            // Snapshot at RD: a write landing this same cycle is seen next frame.
            if (!ph_q) cfg_rd_q <= cfg_q[idx_q];
        end
    end

    // ---------------- accumulator RAM ----------------
    assign inc_rd = INC_W'(cfg_rd_q.inc);

    always_comb begin
        acc_next = acc_rd_q;
        if (state_q == StInit || pend_q[idx_q]) begin
            acc_next = '0;
        end else if (cfg_rd_q.en) begin
            acc_next = acc_rd_q + ACC_W'(inc_rd);
        end
    end

    // Single port: read at RD, write back at WR. Not reset; INIT clears it.
    always_ff @(posedge i_clk) begin
        if (!ph_q) begin
            acc_rd_q <= acc_mem[idx_q];
        end else if (!i_res) begin
            acc_mem[idx_q] <= acc_next;
        end
    end

    // ---------------- shaping and mix ----------------
    dds_wave_lut #(
        .WAVE_W (WAVE_W),
        .AMP_W  (AMP_W)
    ) u_wave_lut (
        .p_i       (acc_rd_q[ACC_W-1 -: WAVE_W]),
        .wave_i    (cfg_rd_q.wave),
        .amp_i     (AMP_W'(cfg_rd_q.amp)),
        .en_i      (cfg_rd_q.en && (state_q == StRun)),
        .contrib_o (contrib)
    );

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            mix_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (ph_q && state_q == StRun) begin
                if (idx_q == '0) mix_q <= OUT_W'(contrib);
                else             mix_q <= mix_q + OUT_W'(contrib);
                if (last_voice) begin
                    sample_q <= mix_q + OUT_W'(contrib);
                    valid_q  <= 1'b1;
                end
            end
        end
    end

    assign o_sample       = sample_q;
    assign o_sample_valid = valid_q;
    assign o_init_busy    = (state_q == StInit);

endmodule

// File: tb/tb_dds_voice_engine.sv
// Directed bench for dds_voice_engine (4 voices) and its waveform shaper.
module tb_dds_voice_engine;

    localparam int NV     = 4;
    localparam int ACC_W  = 26;
    localparam int INC_W  = 26;
    localparam int WAVE_W = 8;
    localparam int AMP_W  = 4;
    localparam int VA_W   = 2;
    localparam int OUT_W  = 14;

    logic              i_clk = 1'b0;
    logic              i_res = 1'b1;
    logic              i_cfg_wren = 1'b0;
    logic [VA_W-1:0]   i_cfg_addr = '0;
    logic              i_cfg_en = 1'b0;
    logic [INC_W-1:0]  i_cfg_inc = '0;
    logic [1:0]        i_cfg_wave = '0;
    logic [AMP_W-1:0]  i_cfg_amp = '0;
    logic              i_cfg_phase_rst = 1'b0;
    logic [OUT_W-1:0]  o_sample;
    logic              o_sample_valid;
    logic              o_init_busy;

    logic [WAVE_W-1:0]       lut_p = '0;
    logic [1:0]              lut_wave = '0;
    logic [AMP_W-1:0]        lut_amp = '0;
    logic                    lut_en = 1'b0;
    logic [WAVE_W+AMP_W-1:0] lut_contrib;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    dds_voice_engine #(
        .NUM_VOICES (NV),
        .ACC_W      (ACC_W),
        .INC_W      (INC_W),
        .WAVE_W     (WAVE_W),
        .AMP_W      (AMP_W)
    ) dut (
        .i_clk           (i_clk),
        .i_res           (i_res),
        .i_cfg_wren      (i_cfg_wren),
        .i_cfg_addr      (i_cfg_addr),
        .i_cfg_en        (i_cfg_en),
        .i_cfg_inc       (i_cfg_inc),
        .i_cfg_wave      (i_cfg_wave),
        .i_cfg_amp       (i_cfg_amp),
        .i_cfg_phase_rst (i_cfg_phase_rst),
        .o_sample        (o_sample),
        .o_sample_valid  (o_sample_valid),
        .o_init_busy     (o_init_busy)
    );

    dds_wave_lut #(
        .WAVE_W (WAVE_W),
        .AMP_W  (AMP_W)
    ) u_lut (
        .p_i       (lut_p),
        .wave_i    (lut_wave),
        .amp_i     (lut_amp),
        .en_i      (lut_en),
        .contrib_o (lut_contrib)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic lut_check(input string tag, input logic [7:0] p, input logic [1:0] w,
                             input logic [3:0] a, input logic en, input int exp);
        lut_p = p; lut_wave = w; lut_amp = a; lut_en = en;
        #1;
        check(tag, 32'(lut_contrib), exp);
    endtask

    task automatic cfg_write(input int addr, input logic en, input logic [INC_W-1:0] inc,
                             input logic [1:0] wave, input logic [AMP_W-1:0] amp,
                             input logic prst);
        i_cfg_wren = 1'b1; i_cfg_addr = VA_W'(addr); i_cfg_en = en; i_cfg_inc = inc;
        i_cfg_wave = wave; i_cfg_amp = amp; i_cfg_phase_rst = prst;
        tick();
        i_cfg_wren = 1'b0; i_cfg_phase_rst = 1'b0;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Waits (bounded) for the next valid pulse and checks the sample there.
    task automatic expect_frame(input string tag, input int exp);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!o_sample_valid && k < 4 * NV);
        check({tag, "_valid_seen"}, 32'(o_sample_valid), 1);
        check(tag, 32'(o_sample), exp);
    endtask

    task automatic skip_frame();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!o_sample_valid && k < 4 * NV);
        check("skip_valid_seen", 32'(o_sample_valid), 1);
    endtask

    // Called in cycle 0 after reset release; returns in cycle 4N+1.
    task automatic init_check(input string tag);
        check({tag, "_sample0"}, 32'(o_sample), 0);
        for (int c = 0; c < 4 * NV; c++) begin
            check({tag, "_busy"}, 32'(o_init_busy), (c < 2 * NV) ? 1 : 0);
            check({tag, "_no_valid"}, 32'(o_sample_valid), 0);
            tick();
        end
        check({tag, "_first_valid"}, 32'(o_sample_valid), 1);
        check({tag, "_first_sample"}, 32'(o_sample), 0);
        tick();
        check({tag, "_pulse_width"}, 32'(o_sample_valid), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Shaper standalone.
        lut_check("lut_saw",      8'h37, 2'd1, 4'd3,  1'b1, 165);
        lut_check("lut_sq_hi",    8'h80, 2'd0, 4'd2,  1'b1, 510);
        lut_check("lut_sq_lo",    8'h7F, 2'd0, 4'd15, 1'b1, 0);
        lut_check("lut_tri_up",   8'h40, 2'd2, 4'd1,  1'b1, 128);
        lut_check("lut_tri_dn",   8'hC0, 2'd2, 4'd1,  1'b1, 127);
        lut_check("lut_tri_dn2",  8'h81, 2'd2, 4'd2,  1'b1, 506);
        lut_check("lut_pulse_hi", 8'hC0, 2'd3, 4'd1,  1'b1, 255);
        lut_check("lut_pulse_lo", 8'hBF, 2'd3, 4'd15, 1'b1, 0);
        lut_check("lut_disabled", 8'hFF, 2'd1, 4'd15, 1'b0, 0);

        // Reset and INIT sweep.
        i_res = 1'b1;
        tick();
        tick();
        i_res = 1'b0;
        cyc = 0;
        init_check("init");

        // Voice 0 square, amp 15, quarter-turn increment. Written in cycle 17.
        cfg_write(0, 1'b1, 26'h1000000, 2'd0, 4'd15, 1'b0);
        expect_frame("sq_f24", 0);
        expect_frame("sq_f32", 0);
        expect_frame("sq_f40", 0);
        expect_frame("sq_f48", 3825);
        expect_frame("sq_f56", 3825);
        expect_frame("sq_f64", 0);

        // Voice 0 off, voice 1 saw amp 1: one LSB per frame, wraps 255 -> 0.
        cfg_write(0, 1'b0, 26'h1000000, 2'd0, 4'd15, 1'b0);
        cfg_write(1, 1'b1, 26'h0040000, 2'd1, 4'd1, 1'b0);
        for (int k = 0; k < 258; k++) expect_frame("saw", k % 256);

        // All four square amp 15, half-turn, aligned via phase reset.
        advance(7);
        for (int v = 0; v < NV; v++) cfg_write(v, 1'b1, 26'h2000000, 2'd0, 4'd15, 1'b1);
        skip_frame();
        expect_frame("all4_a", 0);
        expect_frame("all4_b", 15300);
        expect_frame("all4_c", 0);
        expect_frame("all4_d", 15300);
        expect_frame("all4_e", 0);

        // Voice 2 rewritten in its own RD cycle: old amp this frame.
        advance(4);
        cfg_write(2, 1'b1, 26'h2000000, 2'd0, 4'd5, 1'b0);
        expect_frame("rdw_old", 15300);
        expect_frame("rdw_zero", 0);
        expect_frame("rdw_new", 12750);

        // Phase reset on voice 3 in its WR cycle: flag survives the clear.
        advance(7);
        cfg_write(3, 1'b1, 26'h1000000, 2'd0, 4'd15, 1'b1);
        expect_frame("prst_a", 12750);
        expect_frame("prst_b", 0);
        expect_frame("prst_c", 8925);
        expect_frame("prst_d", 3825);

        // Mid-frame reset: INIT repeats, config cleared.
        advance(3);
        i_res = 1'b1;
        tick();
        i_res = 1'b0;
        cyc = 0;
        init_check("rerst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_voice_engine.md
# dds_voice_engine

Parametrised, time-multiplexed DDS tone generator: NUM_VOICES phase accumulators in a single RAM, scanned at two clocks per voice, each voice with its own increment, waveform and amplitude. Per-voice samples are summed into one unsigned mix word emitted once per frame to the PWM/DAC stage. Successor to the single-bit square-wave DDS, adding a configurable voice count, four waveforms, amplitude scaling, phase reset and a post-reset accumulator clear sweep.

## Interface
- NUM_VOICES, 64: voice count, power of two, ≥2; VA_W = clog2(NUM_VOICES)
- ACC_W, 26: phase accumulator width
- INC_W, 24: increment width, ≤ ACC_W
- WAVE_W, 8: waveform sample width, ≤ ACC_W
- AMP_W, 4: amplitude width; OUT_W = WAVE_W + AMP_W + VA_W
- i_clk  in  1  system clock (one clock domain)
- i_res  in  1  synchronous, active-high reset
- i_cfg_wren  in  1  config write strobe, one voice per cycle
- i_cfg_addr  in  VA_W  voice index
- i_cfg_en  in  1  voice enable
- i_cfg_inc  in  INC_W  phase increment per frame
- i_cfg_wave  in  2  0 square, 1 saw, 2 triangle, 3 pulse-25%
- i_cfg_amp  in  AMP_W  linear amplitude, 0 = silent
- i_cfg_phase_rst  in  1  with i_cfg_wren: zero this voice's accumulator on its next visit
- o_sample  out  OUT_W  mixed sample, unsigned, held between frames
- o_sample_valid  out  1  one-cycle pulse when o_sample updates
- o_init_busy  out  1  high during the post-reset clear sweep

## Operation
- Scanner: phase bit ph toggles each cycle; voice index idx increments after ph=1, wraps NUM_VOICES-1 → 0. Frame = 2·NUM_VOICES cycles.
- ph=0 (RD): address config store and accumulator RAM at idx.
- ph=1 (WR): read data valid. acc_next = phase_rst_pending ? 0 : en ? (acc + zero-extended inc) mod 2^ACC_W : acc. Write acc_next back. Clear pending flag for idx.
- Waveform from p = acc_read[ACC_W-1 -: WAVE_W] (pre-update value): square = p[MSB] ? all-ones : 0; saw = p; triangle = p[MSB] ? ~{p[WAVE_W-2:0],0} : {p[WAVE_W-2:0],0}; pulse-25% = p[MSB:MSB-1]==2'b11 ? all-ones : 0.
- Contribution = en ? wave × amp : 0 (WAVE_W+AMP_W bits). Mix accumulator loads contribution at idx 0, adds otherwise; no overflow possible at OUT_W.
- At WR of idx NUM_VOICES-1: o_sample <= mix + contribution; o_sample_valid pulses next cycle.
- Config writes: stored in flops/RAM addressed by i_cfg_addr, take effect from the next RD of that voice. Write in the same cycle as RD of the same voice: scanner sees old value (read-before-write). Phase-reset flag set and scanner clear in the same cycle: set wins.
- States: INIT (clear sweep), RUN. Reset → INIT: one full frame writing 0 to every accumulator, o_init_busy=1, o_sample_valid suppressed, waveform contributions ignored. After last INIT WR → RUN, idx=0, ph=0.
- Config writes are accepted in INIT and RUN.

## Timing
- Reset values: o_sample=0, o_sample_valid=0, o_init_busy=1, idx=0, ph=0, all enables=0, amp=0, inc=0, wave=0, pending flags=0. Accumulator RAM not reset (cleared by INIT).
- Cycle 0 = first cycle with i_res low. INIT covers cycles 0..2N-1; o_init_busy falls at cycle 2N. First o_sample_valid at cycle 4N, then every 2N cycles.
- Config write latency: voice written at cycle t contributes in the first frame whose RD of that voice is later than t.
- i_res asserted mid-frame: next-cycle state equals reset state; partial mix discarded, no valid pulse; INIT repeats.
- RAM read latency 1 cycle, no output register.

## Structure
- Package dds_pkg: waveform encoding constants (WAVE_SQUARE…WAVE_PULSE25), voice config struct {en, inc, wave, amp}, OUT_W derivation function.
- Sub-module dds_wave_lut: combinational p/wave/amp → contribution shaper, testable standalone.
- Accumulator RAM: inferred single-port, NUM_VOICES × ACC_W, read-then-write per voice.

## Test plan
- Reset, N=4: o_init_busy high cycles 0..7, first o_sample_valid at cycle 16, o_sample=0 with no voices enabled.
- N=4, voice 0 square amp=15, inc=2^(ACC_W-2): o_sample sequence per frame 0,0,3825,3825 repeating (255×15).
- Voice 1 saw amp=1, inc=2^(ACC_W-WAVE_W): o_sample increments by 1 per frame, wraps 255 → 0.
- All 4 voices square amp=15, phase 180° → o_sample 15300 = 4×3825, confirms no overflow at OUT_W.
- Config write to voice 2 in its RD cycle: old value used this frame, new from next; phase_rst on same cycle as scanner clear → accumulator zeroed next frame too.
- i_res pulsed mid-frame: no o_sample_valid for 4N cycles after release, o_sample=0, INIT repeats.
